// File: rtl/piso_shiftreg_tx_if.sv
// -----------------------------------------------------------------------------
// piso_shiftreg_tx_if
//   Bundles the parallel load handshake and the serial output stream of the
//   piso_shiftreg_tx transmitter.
//
//   Parameter:
//     WIDTH        parallel word width in bits
//
//   Signals:
//     din          parallel word offered by the source
//     load_valid   source has a word on din
//     load_ready   transmitter can accept a word this cycle
//     sout         serial data bit
//     sout_valid   sout carries a valid bit this cycle
//     frame_start  first bit of a word is on sout
//     done         last bit of a word (data or parity) is on sout
//
//   Modports:
//     slave   transmitter side (consumes din/load_valid, drives the rest)
//     master  word source / serial sink side
// -----------------------------------------------------------------------------
interface piso_shiftreg_tx_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             done;

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output done
  );

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  done
  );

endinterface : piso_shiftreg_tx_if

// File: rtl/piso_shiftreg_tx.sv
// -----------------------------------------------------------------------------
// piso_shiftreg_tx
//   Parallel-in, serial-out shift register transmitter. A WIDTH-bit word is
//   accepted through a valid/ready handshake and sent out one bit per clock,
//   starting the cycle after the accepting edge. A word accepted during the
//   last bit of the previous word follows it with no idle gap.
//
//   Parameters:
//     WIDTH      word width in bits (>= 2)
//     MSB_FIRST  1: din[WIDTH-1] goes out first; 0: din[0] goes out first
//
//   Optional feature (compile-time macro SHIFTREG_TX_PARITY_EN):
//     when defined, each word is followed by one even-parity bit (XOR of the
//     accepted word), so a frame lasts WIDTH+1 cycles and done/load_ready move
//     to the parity cycle. When undefined the frame is exactly WIDTH bits.
//
//   Ports:
//     clk    rising-edge clock
//     clear  asynchronous reset, active-high
//     bus    piso_shiftreg_tx_if.slave (din, load_valid, load_ready, sout,
//            sout_valid, frame_start, done)
// -----------------------------------------------------------------------------
module piso_shiftreg_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  piso_shiftreg_tx_if.slave     bus
);

  // Counter wide enough to hold WIDTH-1 (WIDTH >= 2 keeps CW >= 1).
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SHIFTREG_TX_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef SHIFTREG_TX_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic [WIDTH-1:0] shreg_shifted;
  logic             last_data_bit;
  logic             done_w;
  logic             load_ready_w;
  logic             load_w;

  // ---------------------------------------------------------------------------
  // Shift by one position with zero fill. The bit on sout is always the one
  // at the "outgoing" end, so shifting exposes the next bit to transmit.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_left
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_q[gi-1];
        end
      end else begin : g_right
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_q[gi+1];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output decode. Everything here is a function of registered state only, so
  // sout, sout_valid, frame_start and done all change together on the clock
  // edge and stay aligned with the bit they describe.
  // ---------------------------------------------------------------------------
  assign last_data_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

`ifdef SHIFTREG_TX_PARITY_EN
  assign done_w = (state_q == PAR);
`else
  assign done_w = last_data_bit;
`endif

  // Accept in IDLE, or during the final bit so the next word follows gaplessly.
  assign load_ready_w = (state_q == IDLE) || done_w;
  assign load_w       = bus.load_valid && load_ready_w;

  always_comb begin
    bus.sout = 1'b0;
    if (state_q == SHIFT) begin
      bus.sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end
`ifdef SHIFTREG_TX_PARITY_EN
    else if (state_q == PAR) begin
      bus.sout = par_q;
    end
`endif
  end

  assign bus.sout_valid  = (state_q != IDLE);
  assign bus.frame_start = (state_q == SHIFT) && (cnt_q == CNT_ZERO);
  assign bus.done        = done_w;
  assign bus.load_ready  = load_ready_w;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SHIFTREG_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_w) begin
          state_d = SHIFT;
          shreg_d = bus.din;
          cnt_d   = CNT_ZERO;
`ifdef SHIFTREG_TX_PARITY_EN
          par_d   = ^bus.din;
`endif
        end
      end

      SHIFT: begin
        if (!last_data_bit) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
`ifdef SHIFTREG_TX_PARITY_EN
          // Parity bit still to send; the next word waits for that cycle.
          state_d = PAR;
          shreg_d = '0;
          cnt_d   = CNT_ZERO;
`else
          if (load_w) begin
            state_d = SHIFT;
            shreg_d = bus.din;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = CNT_ZERO;
          end
`endif
        end
      end

`ifdef SHIFTREG_TX_PARITY_EN
      PAR: begin
        if (load_w) begin
          state_d = SHIFT;
          shreg_d = bus.din;
          cnt_d   = CNT_ZERO;
          par_d   = ^bus.din;
        end else begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = CNT_ZERO;
          par_d   = 1'b0;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = CNT_ZERO;
`ifdef SHIFTREG_TX_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. clear abandons any word in flight immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= CNT_ZERO;
`ifdef SHIFTREG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SHIFTREG_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule : piso_shiftreg_tx

// File: tb/tb_piso_shiftreg_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shiftreg_tx
//   Drives two transmitters (MSB-first and LSB-first) with identical load
//   traffic and compares every cycle against a queue-based frame model: each
//   accepted word appends its bits (and optional parity bit) to a per-DUT
//   queue, whose head is the bit expected on sout in the current cycle.
// -----------------------------------------------------------------------------
module tb_piso_shiftreg_tx;

  localparam int W = 4;
`ifdef SHIFTREG_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int F = W + (PAR_EN ? 1 : 0);

  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } item_t;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  piso_shiftreg_tx_if #(.WIDTH(W)) ifm ();
  piso_shiftreg_tx_if #(.WIDTH(W)) ifl ();

  piso_shiftreg_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .clear (clear),
    .bus   (ifm.slave)
  );

  piso_shiftreg_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .clear (clear),
    .bus   (ifl.slave)
  );

  item_t       qm[$];
  item_t       ql[$];
  logic [31:0] cap_m, cap_l;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: bit order, frame_start on the first bit, done on the last.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back('{b: d[W-1-i], fs: (i == 0), dn: (!PAR_EN && i == W-1)});
      ql.push_back('{b: d[i],     fs: (i == 0), dn: (!PAR_EN && i == W-1)});
    end
    if (PAR_EN) begin
      qm.push_back('{b: ^d, fs: 1'b0, dn: 1'b1});
      ql.push_back('{b: ^d, fs: 1'b0, dn: 1'b1});
    end
  endtask

  task automatic check_side(input string nm, input item_t q[$], input logic so,
                            input logic sv, input logic fs, input logic dn,
                            input logic rdy);
    item_t h;
    if (q.size() == 0) begin
      h = '0;
    end else begin
      h = q[0];
    end
    chk({nm, "_sout"},        {31'd0, so},  {31'd0, h.b});
    chk({nm, "_sout_valid"},  {31'd0, sv},  {31'd0, (q.size() != 0)});
    chk({nm, "_frame_start"}, {31'd0, fs},  {31'd0, h.fs});
    chk({nm, "_done"},        {31'd0, dn},  {31'd0, h.dn});
    chk({nm, "_load_ready"},  {31'd0, rdy}, {31'd0, (q.size() <= 1)});
  endtask

  task automatic check_all();
    check_side("msb", qm, ifm.sout, ifm.sout_valid, ifm.frame_start, ifm.done, ifm.load_ready);
    check_side("lsb", ql, ifl.sout, ifl.sout_valid, ifl.frame_start, ifl.done, ifl.load_ready);
    if (ifm.sout_valid === 1'b1) cap_m = {cap_m[30:0], ifm.sout};
    if (ifl.sout_valid === 1'b1) cap_l = {cap_l[30:0], ifl.sout};
  endtask

  // One clock cycle: drive inputs, predict acceptance, advance, compare.
  task automatic step(input logic lv, input logic [W-1:0] d);
    logic acc;
    ifm.load_valid = lv;
    ifm.din        = d;
    ifl.load_valid = lv;
    ifl.din        = d;
    acc = lv && (qm.size() <= 1);
    @(posedge clk);
    #1;
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (acc) push_word(d);
    $display("t=%0t lv=%b din=%b acc=%b | msb sout=%b v=%b fs=%b dn=%b rdy=%b | lsb sout=%b v=%b fs=%b dn=%b rdy=%b",
             $time, lv, d, acc, ifm.sout, ifm.sout_valid, ifm.frame_start, ifm.done, ifm.load_ready,
             ifl.sout, ifl.sout_valid, ifl.frame_start, ifl.done, ifl.load_ready);
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    clear = 1'b1;
    ifm.load_valid = 1'b0; ifm.din = '0;
    ifl.load_valid = 1'b0; ifl.din = '0;
    cap_m = '0; cap_l = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    clear = 1'b0;
    idle_steps(1);

    // Single word 1011
    cap_m = '0; cap_l = '0;
    step(1'b1, 4'b1011);
    idle_steps(F);
    chk("single_msb_seq", cap_m, PAR_EN ? 32'b10111 : 32'b1011);
    chk("single_lsb_seq", cap_l, PAR_EN ? 32'b11011 : 32'b1101);

    // Single word 1001 (parity 0)
    cap_m = '0; cap_l = '0;
    step(1'b1, 4'b1001);
    idle_steps(F);
    chk("w1001_msb_seq", cap_m, PAR_EN ? 32'b10010 : 32'b1001);
    chk("w1001_lsb_seq", cap_l, PAR_EN ? 32'b10010 : 32'b1001);

    // Back-to-back: load_valid held high, second word taken in the done cycle
    cap_m = '0; cap_l = '0;
    step(1'b1, 4'b1100);
    for (int i = 0; i < F; i++) step(1'b1, 4'b0011);
    idle_steps(F);
    chk("b2b_msb_seq", cap_m, PAR_EN ? 32'b1100000110 : 32'b11000011);
    chk("b2b_lsb_seq", cap_l, PAR_EN ? 32'b0011011000 : 32'b00111100);

    // Stall: din changes while not ready are ignored
    cap_m = '0; cap_l = '0;
    step(1'b1, 4'b1010);
    for (int i = 0; i < F - 1; i++) step(1'b1, 4'b0101);
    step(1'b1, 4'b0111);
    idle_steps(F);
    chk("stall_msb_seq", cap_m, PAR_EN ? 32'b1010001111 : 32'b10100111);
    chk("stall_lsb_seq", cap_l, PAR_EN ? 32'b0101011101 : 32'b01011110);

    // Clear mid-word after two bits, then a clean word
    step(1'b1, 4'b1011);
    step(1'b0, '0);
    #3;
    clear = 1'b1;
    #1;
    qm.delete();
    ql.delete();
    check_all();
    chk("rst_async_ready", {31'd0, ifm.load_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_all();
    clear = 1'b0;
    cap_m = '0; cap_l = '0;
    step(1'b1, 4'b0110);
    idle_steps(F);
    chk("post_rst_msb_seq", cap_m, PAR_EN ? 32'b01100 : 32'b0110);
    chk("post_rst_lsb_seq", cap_l, PAR_EN ? 32'b01100 : 32'b0110);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom));
    end
    idle_steps(F + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso_shiftreg_tx

// File: doc/piso_shiftreg_tx.md
Name: piso_shiftreg_tx

Overview:
Parallel-in, serial-out shift register transmitter. It is the producer end of the serial bit stream that our serial-in shift registers consume.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Drives the word out one bit per clock on sout, qualified by sout_valid.
- Supports gapless back-to-back words.
- Sits between a parallel word source and any serial-in shift register or deserializer clocked by the same clk.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous reset, active-high
din  input  WIDTH  parallel word to transmit
load_valid  input  1  source has a word on din
load_ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid bit this cycle
frame_start  output  1  high during the first bit of a word
done  output  1  high during the last bit of a word (last data bit, or parity bit when PARITY_EN)

Behaviour:
- Reset: clear=1 asynchronously forces the following, regardless of clk:
  - state=IDLE, shift register=0, bit counter=0
  - sout=0, sout_valid=0, frame_start=0, done=0
  - load_ready=1 one combinational step after the state reaches IDLE
- Reset mid-word: the word is abandoned and not resumed. After clear deasserts, the next load starts a fresh word.
- States:
  - IDLE: sout_valid=0, sout=0, load_ready=1.
  - SHIFT: one data bit per cycle, sout_valid=1.
  - PAR (PARITY_EN only): one parity bit, sout_valid=1.
- Handshake: a transfer occurs on a rising edge with load_valid && load_ready. din is sampled only on that edge.
- Latency: the first bit appears on sout in the cycle after the accepting edge (1-cycle latency). The word then occupies exactly WIDTH consecutive cycles (WIDTH+1 with parity).
- Bit order:
  - MSB_FIRST=1: din[WIDTH-1], din[WIDTH-2], ..., din[0].
  - MSB_FIRST=0: din[0] ... din[WIDTH-1].
- Shifting: shift left (MSB_FIRST=1) or right (MSB_FIRST=0), fill with 0. The bit counter counts 0..WIDTH-1 and stops there, with no wrap inside a word.
- load_ready:
  - 1 in IDLE.
  - 1 in the final bit cycle of a word (done=1).
  - 0 otherwise.
- Back-to-back: a word accepted during the final bit cycle produces its first bit on the very next cycle. sout_valid stays 1 and frame_start pulses, with no idle gap.
- End of word with no new word: when the final bit cycle ends without a new load, the block returns to IDLE and sout_valid drops to 0 on the next cycle.
- load_valid while load_ready=0: ignored. The source must hold the word until the handshake completes.
- frame_start and done: both are registered with the data they qualify and are aligned to the same cycle as sout.
- Transitions:
  - IDLE -> SHIFT on a load.
  - SHIFT -> SHIFT while count < WIDTH-1.
  - From SHIFT at count = WIDTH-1:
    - without parity: SHIFT (reloaded) if a load occurs, else IDLE.
    - with parity: PAR.
  - PAR -> SHIFT if a load occurs, else IDLE.

Optional Feature:
Macro SHIFTREG_TX_PARITY_EN.
- Defined: after the WIDTH data bits, one extra cycle drives the even-parity bit (XOR of all WIDTH bits of the accepted word) with sout_valid=1.
  - done moves to the parity cycle; load_ready is high in the parity cycle only.
  - Total cycles per word = WIDTH+1.
- Undefined: the PAR state and parity logic are absent; the frame is exactly WIDTH bits.

Test Plan:
- Reset: assert clear mid-word (after 2 bits of 4'b1011) -> outputs 0 immediately, load_ready=1; after release, load 4'b0110 -> 0,1,1,0 serialised cleanly.
- Single word, WIDTH=4, MSB_FIRST=1, load 4'b1011 -> sout=1,0,1,1 over cycles 1-4 after accept, frame_start on cycle 1, done on cycle 4, then sout_valid=0.
- MSB_FIRST=0, load 4'b1011 -> sout=1,1,0,1.
- Back-to-back: load_valid held high with 4'b1100 then 4'b0011 -> 8 continuous valid bits 1,1,0,0,0,0,1,1; load_ready high only in accept cycle and cycles 4, 8.
- Stall: load_valid=1 during bits 2-3 of a word -> not accepted until the done cycle; din change while load_ready=0 has no effect.
- SHIFTREG_TX_PARITY_EN defined, load 4'b1011 -> 1,0,1,1 then parity 1, done on cycle 5; load 4'b1001 -> parity bit 0.
